// File: rtl/mem_refill_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg -- shared definitions for the cache block-refill controller.
//
// Contents:
//   BLOCK_W      default block width in bits (4 x 32-bit words)
//   WORD_W       memory word / address width
//   OFFSET_BITS  byte-offset bits inside one block
//   state_e      refill controller FSM states
//   block_align  clears the byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int BLOCK_W     = 128;
    localparam int WORD_W      = 32;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        RD_REQ,
        RD_WAIT,
        RESP,
        ERR
    } state_e;

    // Masking (rather than slicing and concatenating) keeps every address
    // bit referenced, so the offset bits do not show up as unused inputs.
    function automatic logic [WORD_W-1:0] block_align(input logic [WORD_W-1:0] addr);
        return addr & ~WORD_W'((1 << OFFSET_BITS) - 1);
    endfunction

endpackage

// File: rtl/mem_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_refill_ctrl_if -- block-transfer bus between the refill controller and
// main memory.
//
// Signals:
//   mem_read_en   controller -> memory  one-cycle block read strobe
//   mem_write_en  controller -> memory  one-cycle block write strobe
//   mem_address   controller -> memory  block-aligned address (0 when idle)
//   mem_wdata     controller -> memory  write-back block
//   mem_block_in  memory -> controller  read data
//   mem_ready     memory -> controller  read data valid
//   mem_wack      memory -> controller  write accepted
//
// Modports: master (controller side), slave (memory side).
// ---------------------------------------------------------------------------
interface mem_refill_ctrl_if #(
    parameter int BLOCK_W = cache_pkg::BLOCK_W
) ();

    logic               mem_read_en;
    logic               mem_write_en;
    logic [31:0]        mem_address;
    logic [BLOCK_W-1:0] mem_wdata;
    logic [BLOCK_W-1:0] mem_block_in;
    logic               mem_ready;
    logic               mem_wack;

    modport master (
        output mem_read_en,
        output mem_write_en,
        output mem_address,
        output mem_wdata,
        input  mem_block_in,
        input  mem_ready,
        input  mem_wack
    );

    modport slave (
        input  mem_read_en,
        input  mem_write_en,
        input  mem_address,
        input  mem_wdata,
        output mem_block_in,
        output mem_ready,
        output mem_wack
    );

endinterface

// File: rtl/mem_refill_ctrl.sv
// ---------------------------------------------------------------------------
// mem_refill_ctrl -- cache miss refill controller.
//
// On a miss it optionally writes the dirty victim block back to memory, then
// reads the missing block, returns it with a one-cycle refill_valid pulse and
// goes idle. A memory that stays silent for TIMEOUT wait cycles aborts the
// transaction with a one-cycle refill_err pulse.
//
// Parameters:
//   TIMEOUT      wait cycles allowed for mem_wack / mem_ready
//   BLOCK_W      block width in bits
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   miss_req     refill request (level, held until busy is seen)
//   miss_addr    byte address of the missing access
//   evict_dirty  victim must be written back first
//   evict_addr   byte address of the victim block
//   evict_data   victim block contents
//   busy         controller not idle
//   refill_valid one-cycle pulse, refill_data valid
//   refill_data  returned block, word i at [i*32 +: 32]; held between refills
//   refill_err   one-cycle pulse, transaction timed out
//   mem          memory bus (master side)
// ---------------------------------------------------------------------------
module mem_refill_ctrl
    import cache_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int BLOCK_W = cache_pkg::BLOCK_W
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               miss_req,
    input  logic [31:0]        miss_addr,
    input  logic               evict_dirty,
    input  logic [31:0]        evict_addr,
    input  logic [BLOCK_W-1:0] evict_data,

    output logic               busy,
    output logic               refill_valid,
    output logic [BLOCK_W-1:0] refill_data,
    output logic               refill_err,

    mem_refill_ctrl_if.master  mem
);

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    // Counter value during the last wait cycle; no response by then -> ERR.
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_e             state;
    state_e             next_state;

    logic [31:0]        miss_blk;
    logic [31:0]        evict_blk;
    logic [BLOCK_W-1:0] evict_buf;
    logic [CNT_W-1:0]   wait_cnt;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs. Strobes and pulses are decoded from the state
    // alone, so reset forces them low immediately and a transaction cut by
    // reset never emits refill_valid or refill_err.
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state       = state;
        busy             = 1'b1;
        refill_valid     = 1'b0;
        refill_err       = 1'b0;
        mem.mem_read_en  = 1'b0;
        mem.mem_write_en = 1'b0;
        mem.mem_address  = '0;
        mem.mem_wdata    = '0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (miss_req) begin
                    next_state = evict_dirty ? WB_REQ : RD_REQ;
                end
            end

            WB_REQ: begin
                mem.mem_write_en = 1'b1;
                mem.mem_address  = evict_blk;
                mem.mem_wdata    = evict_buf;
                next_state       = WB_WAIT;
            end

            // A response in the final wait cycle is checked first, so it
            // beats the timeout.
            WB_WAIT: begin
                if (mem.mem_wack) begin
                    next_state = RD_REQ;
                end else if (wait_cnt == LAST_WAIT) begin
                    next_state = ERR;
                end
            end

            RD_REQ: begin
                mem.mem_read_en = 1'b1;
                mem.mem_address = miss_blk;
                next_state      = RD_WAIT;
            end

            RD_WAIT: begin
                if (mem.mem_ready) begin
                    next_state = RESP;
                end else if (wait_cnt == LAST_WAIT) begin
                    next_state = ERR;
                end
            end

            RESP: begin
                refill_valid = 1'b1;
                next_state   = IDLE;
            end

            ERR: begin
                refill_err = 1'b1;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: request latches, wait counter, refill buffer
    // -----------------------------------------------------------------------
    // NOTE: the data registers are reset too, because refill_data and the
    // latched request must read as zero after reset, not just the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_blk    <= '0;
            evict_blk   <= '0;
            evict_buf   <= '0;
            wait_cnt    <= '0;
            refill_data <= '0;
        end else begin
            if (state == IDLE && miss_req) begin
                miss_blk  <= block_align(miss_addr);
                evict_blk <= block_align(evict_addr);
                evict_buf <= evict_data;
            end

            // The request states clear the counter, so the first wait cycle
            // always starts at zero.
            if (state == WB_REQ || state == RD_REQ) begin
                wait_cnt <= '0;
            end else if (state == WB_WAIT || state == RD_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (state == RD_WAIT && mem.mem_ready) begin
                refill_data <= mem.mem_block_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_refill_ctrl -- directed self-checking bench for mem_refill_ctrl.
//
// Memory model: word i of a block = aligned address + i; mem_ready follows
// mem_read_en by one cycle and mem_wack follows mem_write_en by one cycle
// while resp_en is set. force_ready/force_block inject a response by hand.
// Stimulus changes and checks happen on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_refill_ctrl;

    localparam int BW = 128;

    logic          clk;
    logic          rst_n;
    logic          miss_req;
    logic [31:0]   miss_addr;
    logic          evict_dirty;
    logic [31:0]   evict_addr;
    logic [BW-1:0] evict_data;
    logic          busy;
    logic          refill_valid;
    logic [BW-1:0] refill_data;
    logic          refill_err;

    mem_refill_ctrl_if #(.BLOCK_W(BW)) mif ();

    mem_refill_ctrl #(
        .TIMEOUT (15),
        .BLOCK_W (BW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .evict_dirty  (evict_dirty),
        .evict_addr   (evict_addr),
        .evict_data   (evict_data),
        .busy         (busy),
        .refill_valid (refill_valid),
        .refill_data  (refill_data),
        .refill_err   (refill_err),
        .mem          (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_block(input logic [31:0] a);
        return {a + 32'd3, a + 32'd2, a + 32'd1, a};
    endfunction

    // ---------------- memory model ----------------
    logic          resp_en;
    logic          force_ready;
    logic [BW-1:0] force_block;
    logic          pend_rd;
    logic          pend_wr;
    logic [31:0]   pend_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rd   <= 1'b0;
            pend_wr   <= 1'b0;
            pend_addr <= '0;
        end else begin
            pend_rd <= mif.mem_read_en && resp_en;
            pend_wr <= mif.mem_write_en && resp_en;
            if (mif.mem_read_en) pend_addr <= mif.mem_address;
        end
    end

    assign mif.mem_ready    = pend_rd | force_ready;
    assign mif.mem_wack     = pend_wr;
    assign mif.mem_block_in = force_ready ? force_block : model_block(pend_addr);

    // ---------------- monitor ----------------
    int          cyc     = 0;
    int          n_valid = 0;
    int          n_err   = 0;
    int          n_rd    = 0;
    int          n_wr    = 0;
    int          wr_cyc  = 0;
    int          rd_cyc  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (refill_valid)     n_valid <= n_valid + 1;
        if (refill_err)       n_err   <= n_err + 1;
        if (mif.mem_write_en) begin n_wr <= n_wr + 1; wr_cyc <= cyc; end
        if (mif.mem_read_en)  begin n_rd <= n_rd + 1; rd_cyc <= cyc; end
    end

    // Bus invariant: strobes exclusive, address zero when no strobe.
    always @(negedge clk) begin
        checks++;
        assert (!(mif.mem_read_en && mif.mem_write_en) &&
                (mif.mem_read_en || mif.mem_write_en || mif.mem_address == 32'd0)) else begin
            failures++;
            $error("FAIL bus_invariant observed=rd%0b/wr%0b/addr%0h expected=exclusive strobes, addr 0 when idle",
                   mif.mem_read_en, mif.mem_write_en, mif.mem_address);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    logic [BW-1:0] data_d;
    logic [BW-1:0] held;
    int            base_a;
    int            base_b;
    int            base_c;

    initial begin
        rst_n       = 1'b0;
        miss_req    = 1'b0;
        miss_addr   = '0;
        evict_dirty = 1'b0;
        evict_addr  = '0;
        evict_data  = '0;
        resp_en     = 1'b1;
        force_ready = 1'b0;
        force_block = '0;
        data_d      = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF};

        // Reset state
        step();
        step();
        check("rst_busy",   BW'(busy), BW'(0));
        check("rst_valid",  BW'(refill_valid), BW'(0));
        check("rst_err",    BW'(refill_err), BW'(0));
        check("rst_rd",     BW'(mif.mem_read_en), BW'(0));
        check("rst_wr",     BW'(mif.mem_write_en), BW'(0));
        check("rst_data",   refill_data, BW'(0));
        check("rst_wdata",  mif.mem_wdata, BW'(0));
        rst_n = 1'b1;
        step();

        // Clean miss: latency and data
        base_a      = n_valid;
        miss_req    = 1'b1;
        miss_addr   = 32'h0000_1234;
        evict_dirty = 1'b0;
        evict_addr  = 32'h9999_0000;
        evict_data  = data_d;
        step();                                    // cycle 1
        check("clean_c1_rd",   BW'(mif.mem_read_en), BW'(1));
        check("clean_c1_wr",   BW'(mif.mem_write_en), BW'(0));
        check("clean_c1_addr", BW'(mif.mem_address), BW'(32'h0000_1230));
        check("clean_c1_busy", BW'(busy), BW'(1));
        miss_req = 1'b0;
        step();                                    // cycle 2
        check("clean_c2_rd",    BW'(mif.mem_read_en), BW'(0));
        check("clean_c2_valid", BW'(refill_valid), BW'(0));
        step();                                    // cycle 3
        check("clean_c3_valid", BW'(refill_valid), BW'(1));
        check("clean_c3_data",  refill_data, model_block(32'h0000_1230));
        check("clean_w0",       BW'(refill_data[31:0]), BW'(32'h0000_1230));
        check("clean_w3",       BW'(refill_data[127:96]), BW'(32'h0000_1233));
        step();
        check("clean_c4_valid", BW'(refill_valid), BW'(0));
        check("clean_c4_busy",  BW'(busy), BW'(0));
        check("clean_hold",     refill_data, model_block(32'h0000_1230));
        check("clean_npulse",   BW'(n_valid - base_a), BW'(1));

        // Dirty miss: write-back then read
        base_a      = n_wr;
        base_b      = n_rd;
        miss_req    = 1'b1;
        miss_addr   = 32'h0000_5678;
        evict_dirty = 1'b1;
        evict_addr  = 32'h0000_2008;
        evict_data  = data_d;
        step();                                    // cycle 1: WB_REQ
        check("dirty_c1_wr",    BW'(mif.mem_write_en), BW'(1));
        check("dirty_c1_rd",    BW'(mif.mem_read_en), BW'(0));
        check("dirty_c1_addr",  BW'(mif.mem_address), BW'(32'h0000_2000));
        check("dirty_c1_wdata", mif.mem_wdata, data_d);
        miss_req    = 1'b0;
        evict_dirty = 1'b0;
        evict_data  = '0;
        step();                                    // cycle 2: WB_WAIT
        check("dirty_c2_wr",    BW'(mif.mem_write_en), BW'(0));
        check("dirty_c2_busy",  BW'(busy), BW'(1));
        step();                                    // cycle 3: RD_REQ
        check("dirty_c3_rd",    BW'(mif.mem_read_en), BW'(1));
        check("dirty_c3_addr",  BW'(mif.mem_address), BW'(32'h0000_5670));
        step();                                    // cycle 4: RD_WAIT
        step();                                    // cycle 5: RESP
        check("dirty_c5_valid", BW'(refill_valid), BW'(1));
        check("dirty_c5_data",  refill_data, model_block(32'h0000_5670));
        check("dirty_nwr",      BW'(n_wr - base_a), BW'(1));
        check("dirty_nrd",      BW'(n_rd - base_b), BW'(1));
        check("dirty_order",    BW'(wr_cyc < rd_cyc), BW'(1));
        step();

        // Read timeout: 15 silent wait cycles, then ERR
        held     = model_block(32'h0000_5670);
        base_a   = n_err;
        base_b   = n_valid;
        resp_en  = 1'b0;
        miss_req = 1'b1;
        miss_addr = 32'hABCD_0010;
        step();                                    // cycle 1: RD_REQ
        miss_req = 1'b0;
        repeat (15) step();                        // cycle 16: 15th wait cycle
        check("to_c16_err",   BW'(refill_err), BW'(0));
        check("to_c16_busy",  BW'(busy), BW'(1));
        step();                                    // cycle 17: ERR
        check("to_c17_err",   BW'(refill_err), BW'(1));
        check("to_c17_valid", BW'(refill_valid), BW'(0));
        step();
        check("to_err_drop",  BW'(refill_err), BW'(0));
        check("to_busy_drop", BW'(busy), BW'(0));
        check("to_data_held", refill_data, held);
        check("to_nerr",      BW'(n_err - base_a), BW'(1));
        check("to_nvalid",    BW'(n_valid - base_b), BW'(0));

        // Write-back timeout: no read is ever issued
        base_a      = n_err;
        base_b      = n_rd;
        miss_req    = 1'b1;
        miss_addr   = 32'h0000_0100;
        evict_dirty = 1'b1;
        evict_addr  = 32'h0000_0F00;
        step();                                    // cycle 1: WB_REQ
        miss_req    = 1'b0;
        evict_dirty = 1'b0;
        repeat (15) step();                        // cycle 16
        check("wbto_c16_err", BW'(refill_err), BW'(0));
        step();                                    // cycle 17: ERR
        check("wbto_c17_err", BW'(refill_err), BW'(1));
        step();
        check("wbto_nrd",     BW'(n_rd - base_b), BW'(0));
        check("wbto_nerr",    BW'(n_err - base_a), BW'(1));

        // Response in the last wait cycle beats the timeout
        base_a    = n_err;
        miss_req  = 1'b1;
        miss_addr = 32'h0000_7004;
        step();                                    // cycle 1: RD_REQ
        miss_req = 1'b0;
        repeat (15) step();                        // cycle 16: last wait cycle
        force_ready = 1'b1;
        force_block = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        step();                                    // cycle 17
        force_ready = 1'b0;
        check("edge_valid", BW'(refill_valid), BW'(1));
        check("edge_err",   BW'(refill_err), BW'(0));
        check("edge_data",  refill_data, {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444});
        step();
        check("edge_nerr",  BW'(n_err - base_a), BW'(0));
        check("edge_idle",  BW'(busy), BW'(0));

        // miss_req toggled while busy: a single transaction
        resp_en   = 1'b1;
        base_a    = n_valid;
        base_b    = n_rd;
        miss_req  = 1'b1;
        miss_addr = 32'h0000_3000;
        step();                                    // cycle 1
        miss_req  = 1'b0;
        miss_addr = 32'h0000_4440;
        step();                                    // cycle 2
        miss_req  = 1'b1;
        step();                                    // cycle 3: RESP
        check("tog_data", refill_data, model_block(32'h0000_3000));
        miss_req = 1'b0;
        repeat (4) step();
        check("tog_nvalid", BW'(n_valid - base_a), BW'(1));
        check("tog_nrd",    BW'(n_rd - base_b), BW'(1));
        check("tog_idle",   BW'(busy), BW'(0));

        // Reset during RD_WAIT
        resp_en   = 1'b0;
        miss_req  = 1'b1;
        miss_addr = 32'h0000_6000;
        step();                                    // cycle 1: RD_REQ
        miss_req = 1'b0;
        step();                                    // cycle 2: RD_WAIT
        base_a = n_valid;
        base_c = n_err;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy",  BW'(busy), BW'(0));
        check("rstmid_rd",    BW'(mif.mem_read_en), BW'(0));
        check("rstmid_addr",  BW'(mif.mem_address), BW'(0));
        check("rstmid_data",  refill_data, BW'(0));
        check("rstmid_valid", BW'(refill_valid), BW'(0));
        check("rstmid_err",   BW'(refill_err), BW'(0));
        step();
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check("rstmid_nvalid", BW'(n_valid - base_a), BW'(0));
        check("rstmid_nerr",   BW'(n_err - base_c), BW'(0));

        // Normal miss after reset
        resp_en   = 1'b1;
        miss_req  = 1'b1;
        miss_addr = 32'h0000_8124;
        step();                                    // cycle 1
        check("post_rd",   BW'(mif.mem_read_en), BW'(1));
        check("post_addr", BW'(mif.mem_address), BW'(32'h0000_8120));
        miss_req = 1'b0;
        step();                                    // cycle 2
        step();                                    // cycle 3
        check("post_valid", BW'(refill_valid), BW'(1));
        check("post_data",  refill_data, model_block(32'h0000_8120));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
